// File: rtl/mgmt_rx_irq_coalescer.sv
// -----------------------------------------------------------------------------
// mgmt_rx_irq_coalescer
//
// Schedules the "RX frame ready" interrupt from the management RX frame buffer
// to the QSPI host MCU. Counts committed-but-unpopped frames and raises a level
// IRQ when the count reaches a threshold or when the oldest pending frame has
// waited for a timeout. After the IRQ drops, a minimum deasserted gap is
// enforced so the host is not interrupted once per frame under load.
//
// Ports:
//   clk            management clock
//   reset          synchronous, active-high reset
//   frame_commit   1-cycle pulse: frame committed to the RX buffer
//   frame_pop      1-cycle pulse: host popped one frame
//   link_up        link state; low flushes the pending state
//   cfg_threshold  pending count that forces the IRQ (0 treated as 1)
//   cfg_timeout    cycles from first pending frame to forced IRQ (0 = immediate)
//   cfg_gap        minimum IRQ-low cycles after the IRQ drops
//   irq_ack        1-cycle pulse: host serviced the interrupt
//   irq            registered level interrupt to the MCU
//   pending_count  committed, unpopped frames
//   err_underflow  sticky: pop seen with pending_count == 0
//   err_overflow   sticky: commit seen with the counter saturated
//
// Optional build macro MGMT_IRQ_COALESCE_STATS_EN adds:
//   irq_count      16-bit wrapping count of entries to the asserted state
//   max_wait       largest ARMED timer value seen at assertion, saturating
// -----------------------------------------------------------------------------
module mgmt_rx_irq_coalescer #(
   parameter int COUNT_WIDTH = 6,
   parameter int TIMER_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_commit,
   input  logic                   frame_pop,
   input  logic                   link_up,
   input  logic [COUNT_WIDTH-1:0] cfg_threshold,
   input  logic [TIMER_WIDTH-1:0] cfg_timeout,
   input  logic [TIMER_WIDTH-1:0] cfg_gap,
   input  logic                   irq_ack,
   output logic                   irq,
   output logic [COUNT_WIDTH-1:0] pending_count,
   output logic                   err_underflow,
   output logic                   err_overflow
`ifdef MGMT_IRQ_COALESCE_STATS_EN
   ,
   output logic [15:0]            irq_count,
   output logic [TIMER_WIDTH-1:0] max_wait
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ASSERTED, S_GAP} state_t;

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
   localparam logic [TIMER_WIDTH-1:0] TMR_ONE = TIMER_WIDTH'(1);

   state_t                 r_state;
   logic                   r_irq;
   logic [COUNT_WIDTH-1:0] r_count;
   logic [TIMER_WIDTH-1:0] r_timer;
   logic [TIMER_WIDTH-1:0] r_gap;
   logic                   r_err_unf;
   logic                   r_err_ovf;

   logic [COUNT_WIDTH-1:0] w_count_next;
   logic                   w_unf_evt;
   logic                   w_ovf_evt;
   logic [COUNT_WIDTH-1:0] w_thresh;
   logic                   w_thresh_hit;
   logic [TIMER_WIDTH:0]   w_timer_inc;
   logic                   w_timeout_hit;
   logic                   w_has_pending;
   logic                   w_idle_fire;
   logic                   w_armed_fire;

   // Post-update count: every state decision below looks at this value so a
   // commit is acted on at the same edge it is counted.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_count_next = r_count;
      w_unf_evt    = 1'b0;
      w_ovf_evt    = 1'b0;
      if (frame_commit && !frame_pop) begin
         if (&r_count) w_ovf_evt    = 1'b1;
         else          w_count_next = r_count + CNT_ONE;
      end else if (frame_pop && !frame_commit) begin
         if (r_count == '0) w_unf_evt    = 1'b1;
         else               w_count_next = r_count - CNT_ONE;
      end
      if (!link_up) w_count_next = '0;
   end

   assign w_thresh      = (cfg_threshold == '0) ? CNT_ONE : cfg_threshold;
   assign w_thresh_hit  = (w_count_next >= w_thresh);
   // One bit wider so timer+1 cannot wrap when the timer is saturated.
   assign w_timer_inc   = {1'b0, r_timer} + {{TIMER_WIDTH{1'b0}}, 1'b1};
   assign w_timeout_hit = (cfg_timeout == '0) || (w_timer_inc >= {1'b0, cfg_timeout});
   assign w_has_pending = (w_count_next != '0);
   // From IDLE only the threshold and zero-timeout conditions can fire at once;
   // a non-zero timeout always runs from ARMED entry.
   assign w_idle_fire   = w_has_pending && (w_thresh_hit || cfg_timeout == '0);
   assign w_armed_fire  = w_has_pending && (w_thresh_hit || w_timeout_hit);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         r_state   <= S_IDLE;
         r_irq     <= 1'b0;
         r_count   <= '0;
         r_timer   <= '0;
         r_gap     <= '0;
         r_err_unf <= 1'b0;
         r_err_ovf <= 1'b0;
      end else begin
         r_count <= w_count_next;
         if (w_unf_evt) r_err_unf <= 1'b1;
         if (w_ovf_evt) r_err_ovf <= 1'b1;

         if (!link_up) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
            r_timer <= '0;
            r_gap   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_has_pending) begin
                     r_timer <= '0;
                     if (w_idle_fire) begin
                        r_state <= S_ASSERTED;
                        r_irq   <= 1'b1;
                     end else begin
                        r_state <= S_ARMED;
                     end
                  end
               end
               S_ARMED: begin
                  if (!w_has_pending) begin
                     r_state <= S_IDLE;
                  end else if (w_armed_fire) begin
                     r_state <= S_ASSERTED;
                     r_irq   <= 1'b1;
                  end else if (!(&r_timer)) begin
                     r_timer <= r_timer + TMR_ONE;
                  end
               end
               S_ASSERTED: begin
                  if (irq_ack || !w_has_pending) begin
                     r_irq <= 1'b0;
                     if (cfg_gap == '0) begin
                        r_timer <= '0;
                        r_state <= w_has_pending ? S_ARMED : S_IDLE;
                     end else begin
                        r_gap   <= cfg_gap - TMR_ONE;
                        r_state <= S_GAP;
                     end
                  end
               end
               S_GAP: begin
                  if (r_gap == '0) begin
                     r_timer <= '0;
                     r_state <= w_has_pending ? S_ARMED : S_IDLE;
                  end else begin
                     r_gap <= r_gap - TMR_ONE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_irq   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign irq           = r_irq;
   assign pending_count = r_count;
   assign err_underflow = r_err_unf;
   assign err_overflow  = r_err_ovf;

`ifdef MGMT_IRQ_COALESCE_STATS_EN
   logic [15:0]            r_irq_count;
   logic [TIMER_WIDTH-1:0] r_max_wait;
   logic                   w_enter;
   logic [TIMER_WIDTH-1:0] w_wait;

   assign w_enter = link_up && ((r_state == S_IDLE  && w_idle_fire) ||
                                (r_state == S_ARMED && w_armed_fire));
   // A direct IDLE->ASSERTED entry has waited zero cycles.
   assign w_wait  = (r_state == S_ARMED) ? r_timer : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_count <= '0;
         r_max_wait  <= '0;
      end else if (w_enter) begin
         r_irq_count <= r_irq_count + 16'd1;
         if (w_wait > r_max_wait) r_max_wait <= w_wait;
      end
   end

   assign irq_count = r_irq_count;
   assign max_wait  = r_max_wait;
`endif

endmodule

// File: tb/tb_mgmt_rx_irq_coalescer.sv
// -----------------------------------------------------------------------------
// Testbench for mgmt_rx_irq_coalescer. A table of single-cycle vectors covers
// counting, threshold assertion, drain-without-ack and sticky underflow; hand
// sequences cover timeout, gap, link drop, overflow and reset mid-gap.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_mgmt_rx_irq_coalescer;

   logic        clk;
   logic        reset;
   logic        frame_commit;
   logic        frame_pop;
   logic        link_up;
   logic [5:0]  cfg_threshold;
   logic [15:0] cfg_timeout;
   logic [15:0] cfg_gap;
   logic        irq_ack;
   logic        irq;
   logic [5:0]  pending_count;
   logic        err_underflow;
   logic        err_overflow;
`ifdef MGMT_IRQ_COALESCE_STATS_EN
   logic [15:0] irq_count;
   logic [15:0] max_wait;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   mgmt_rx_irq_coalescer #(.COUNT_WIDTH(6), .TIMER_WIDTH(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .frame_commit  (frame_commit),
      .frame_pop     (frame_pop),
      .link_up       (link_up),
      .cfg_threshold (cfg_threshold),
      .cfg_timeout   (cfg_timeout),
      .cfg_gap       (cfg_gap),
      .irq_ack       (irq_ack),
      .irq           (irq),
      .pending_count (pending_count),
      .err_underflow (err_underflow),
      .err_overflow  (err_overflow)
`ifdef MGMT_IRQ_COALESCE_STATS_EN
      ,
      .irq_count     (irq_count),
      .max_wait      (max_wait)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         wait_cyc;
      logic       commit;
      logic       pop;
      logic       ack;
      logic       link;
      logic       exp_irq;
      logic [5:0] exp_count;
      logic       exp_unf;
      string      name;
   } vec_t;

   vec_t vq[$];

   task automatic add(input int w, input logic c, input logic p, input logic a,
                      input logic l, input logic ei, input logic [5:0] ec,
                      input logic eu, input string nm);
      vec_t v;
      v.wait_cyc = w;  v.commit = c;     v.pop = p;     v.ack = a; v.link = l;
      v.exp_irq  = ei; v.exp_count = ec; v.exp_unf = eu; v.name = nm;
      vq.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic c, input logic p, input logic a);
      frame_commit = c;
      frame_pop    = p;
      irq_ack      = a;
      tick();
      frame_commit = 1'b0;
      frame_pop    = 1'b0;
      irq_ack      = 1'b0;
   endtask

   initial begin
      logic stayed_low;

      reset         = 1'b1;
      frame_commit  = 1'b0;
      frame_pop     = 1'b0;
      irq_ack       = 1'b0;
      link_up       = 1'b1;
      cfg_threshold = 6'd4;
      cfg_timeout   = 16'd1000;
      cfg_gap       = 16'd0;

      // Reset state
      tick();
      tick();
      check("rst_irq",   irq,           0);
      check("rst_count", pending_count, 0);
      check("rst_unf",   err_underflow, 0);
      check("rst_ovf",   err_overflow,  0);
`ifdef MGMT_IRQ_COALESCE_STATS_EN
      check("rst_irq_count", irq_count, 0);
      check("rst_max_wait",  max_wait,  0);
`endif
      reset = 1'b0;

      // Threshold 4, timeout 1000, gap 0
      //   wait  c  p  a  l  irq cnt unf
      add(5, 1, 0, 0, 1, 0, 6'd1, 0, "thr_c1");
      add(9, 1, 0, 0, 1, 0, 6'd2, 0, "thr_c2");
      add(9, 1, 0, 0, 1, 0, 6'd3, 0, "thr_c3");
      add(8, 0, 0, 0, 1, 0, 6'd3, 0, "thr_pre4");
      add(0, 1, 0, 0, 1, 1, 6'd4, 0, "thr_c4");
      add(3, 0, 1, 0, 1, 1, 6'd3, 0, "drain_p1");
      add(0, 0, 1, 0, 1, 1, 6'd2, 0, "drain_p2");
      add(0, 1, 1, 0, 1, 1, 6'd2, 0, "drain_cp");
      add(0, 0, 1, 0, 1, 1, 6'd1, 0, "drain_p3");
      add(0, 0, 1, 0, 1, 0, 6'd0, 0, "drain_p4");
      add(0, 0, 1, 0, 1, 0, 6'd0, 1, "unf_pop0");
      add(5, 0, 0, 0, 1, 0, 6'd0, 1, "unf_sticky");
      add(0, 0, 0, 1, 1, 0, 6'd0, 1, "ack_idle");
      add(0, 1, 0, 0, 1, 0, 6'd1, 1, "cp_c1");
      add(0, 1, 0, 0, 1, 0, 6'd2, 1, "cp_c2");
      add(0, 1, 0, 0, 1, 0, 6'd3, 1, "cp_c3");
      add(0, 1, 1, 0, 1, 0, 6'd3, 1, "cp_same");
      add(0, 0, 0, 0, 0, 0, 6'd0, 1, "link_flush");

      for (int i = 0; i < vq.size(); i++) begin
         repeat (vq[i].wait_cyc) tick();
         link_up = vq[i].link;
         pulse(vq[i].commit, vq[i].pop, vq[i].ack);
         link_up = 1'b1;
         check({vq[i].name, "_irq"},   irq,           vq[i].exp_irq);
         check({vq[i].name, "_count"}, pending_count, vq[i].exp_count);
         check({vq[i].name, "_unf"},   err_underflow, vq[i].exp_unf);
      end

      // Timeout path: threshold 8 not reached, irq exactly 50 cycles after ARMED entry
      cfg_threshold = 6'd8;
      cfg_timeout   = 16'd50;
      tick();
      pulse(1, 0, 0);
      check("to_armed_irq", irq, 0);
      stayed_low = 1'b1;
      for (int i = 1; i < 50; i++) begin
         tick();
         if (irq !== 1'b0) stayed_low = 1'b0;
      end
      check("to_low_49", stayed_low, 1);
      tick();
      check("to_fire_50", irq, 1);
`ifdef MGMT_IRQ_COALESCE_STATS_EN
      check("to_max_wait",  max_wait,  49);
      check("to_irq_count", irq_count, 2);
`endif
      pulse(0, 1, 0);
      check("to_drain_irq",   irq,           0);
      check("to_drain_count", pending_count, 0);

      // Threshold 1: immediate irq; ack returns to ARMED and, with the
      // threshold raised live to 2, the 100-cycle timeout re-raises irq.
      cfg_threshold = 6'd1;
      cfg_timeout   = 16'd100;
      repeat (4) tick();
      pulse(1, 0, 0);
      check("imm_irq",   irq,           1);
      check("imm_count", pending_count, 1);
      repeat (3) tick();
      check("imm_hold", irq, 1);
      cfg_threshold = 6'd2;
      pulse(0, 0, 1);
      check("ack_drop", irq, 0);
      stayed_low = 1'b1;
      for (int i = 1; i < 100; i++) begin
         tick();
         if (irq !== 1'b0) stayed_low = 1'b0;
      end
      check("rearm_low_99", stayed_low, 1);
      tick();
      check("rearm_fire_100", irq, 1);
      pulse(0, 1, 0);
      check("rearm_drain_irq", irq, 0);

      // Gap of 20 after an ack with 2 pending; a commit inside the gap is
      // counted but cannot raise irq.
      cfg_threshold = 6'd2;
      cfg_timeout   = 16'd1000;
      cfg_gap       = 16'd20;
      tick();
      pulse(1, 0, 0);
      check("gap_c1_irq", irq, 0);
      pulse(1, 0, 0);
      check("gap_c2_irq", irq, 1);
      pulse(0, 0, 1);
      check("gap_ack_irq", irq, 0);
      stayed_low = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         if (i == 5) pulse(1, 0, 0);
         else        tick();
         if (irq !== 1'b0) stayed_low = 1'b0;
      end
      check("gap_low_20", stayed_low, 1);
      check("gap_count",  pending_count, 3);
      tick();
      check("gap_rearm_irq", irq, 1);

      // Link drop while asserted with 5 pending
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      check("ld_pre_irq",   irq,           1);
      check("ld_pre_count", pending_count, 5);
      link_up = 1'b0;
      tick();
      link_up = 1'b1;
      check("ld_irq",   irq,           0);
      check("ld_count", pending_count, 0);
      check("ld_unf",   err_underflow, 1);
      tick();
      check("ld_idle_irq", irq, 0);

      // Overflow: 63 commits fill the counter, the 64th saturates
      cfg_threshold = 6'd1;
      cfg_gap       = 16'd0;
      repeat (63) pulse(1, 0, 0);
      check("ovf_count63", pending_count, 63);
      check("ovf_not_yet", err_overflow,  0);
      pulse(1, 0, 0);
      check("ovf_hold", pending_count, 63);
      check("ovf_flag", err_overflow,  1);
      check("ovf_irq",  irq,           1);

      // Reset in the middle of GAP
      cfg_gap = 16'd20;
      pulse(0, 0, 1);
      check("rg_gap_irq", irq, 0);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("rg_irq",   irq,           0);
      check("rg_count", pending_count, 0);
      check("rg_unf",   err_underflow, 0);
      check("rg_ovf",   err_overflow,  0);
`ifdef MGMT_IRQ_COALESCE_STATS_EN
      check("rg_irq_count", irq_count, 0);
`endif
      reset = 1'b0;
      tick();
      check("rg_after_irq", irq, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mgmt_rx_irq_coalescer.md
Name: mgmt_rx_irq_coalescer

Overview:
- Schedules the "RX frame ready" interrupt from the management RX frame buffer to the QSPI host MCU.
- Tracks how many frames are committed but not yet popped.
- Raises a level IRQ when the pending count reaches a threshold, or when the oldest pending frame has waited for a timeout.
- Enforces a minimum IRQ-deasserted gap so the host is not interrupted once per frame under load.
- Sits between the RX frame FIFO's commit/pop strobes and the MCU IRQ pin. Configuration comes from a management register block.

Parameters:
- COUNT_WIDTH, 6: width of the pending-frame counter (covers a 32-entry header FIFO).
- TIMER_WIDTH, 16: width of the timeout and gap timers and their config inputs.

Ports:
- clk  in  1  single clock (management clock domain).
- reset  in  1  synchronous, active-high reset.
- frame_commit  in  1  one-cycle pulse: a complete frame has been committed to the RX buffer.
- frame_pop  in  1  one-cycle pulse: the host popped one frame.
- link_up  in  1  Ethernet link state; low flushes the pending state.
- cfg_threshold  in  COUNT_WIDTH  pending count that forces the IRQ; 0 is treated as 1.
- cfg_timeout  in  TIMER_WIDTH  cycles from the first pending frame to a forced IRQ; 0 means immediate.
- cfg_gap  in  TIMER_WIDTH  minimum IRQ-low cycles after the IRQ drops.
- irq_ack  in  1  one-cycle pulse from the host: interrupt serviced.
- irq  out  1  registered level interrupt to the MCU.
- pending_count  out  COUNT_WIDTH  current count of committed, unpopped frames.
- err_underflow  out  1  sticky: a pop occurred with pending_count == 0.
- err_overflow  out  1  sticky: a commit occurred with the counter saturated.

Behaviour:
- Reset (reset=1 at a clk edge):
  - pending_count=0, irq=0, err_underflow=0, err_overflow=0.
  - state=IDLE, timers=0.
  - Reset overrides every other input, including mid-ASSERTED and mid-GAP.
- Counter update, each edge:
  - commit only: +1.
  - pop only: -1.
  - commit and pop together: no change.
  - Commit at all-ones: counter holds and err_overflow is set.
  - Pop at 0 (without a simultaneous commit): counter holds and err_underflow is set.
- link_up=0: pending_count cleared to 0 and state forced to IDLE with irq=0. Sticky errors are kept.
- Next-state logic always uses the post-update count (pcount_next), so a commit is seen on the same edge it is counted.
- IDLE (irq=0):
  - Go to ARMED when pcount_next>0.
  - On entry to ARMED, the timer is cleared to 0.
- ARMED (irq=0):
  - Timer increments each cycle and saturates at all-ones.
  - Go to ASSERTED when pcount_next >= max(cfg_threshold,1), or when timer+1 >= cfg_timeout, or when cfg_timeout==0.
  - Go back to IDLE if pcount_next==0.
  - Threshold has priority; the result is the same either way.
- ASSERTED (irq=1):
  - Exit on irq_ack, or when pcount_next==0 (host drained the buffer without acking).
  - If cfg_gap==0, exit goes directly to ARMED (if pcount_next>0, timer cleared) or IDLE.
  - Otherwise exit goes to GAP with the gap timer loaded with cfg_gap-1.
  - irq_ack outside ASSERTED is ignored.
- GAP (irq=0):
  - Gap timer decrements each cycle.
  - When it reads 0, go to ARMED (timer cleared) if pcount_next>0, else IDLE.
  - Commits during GAP are counted but cannot raise irq.
- irq is registered and equals (state==ASSERTED).
  - Latency: a commit pulse in cycle 0 with threshold met gives irq=1 in cycle 1.
  - Timeout path: irq=1 in cycle cfg_timeout after ARMED entry.
- Config inputs are sampled live every cycle. Changing them mid-ARMED takes effect on the next comparison, with no restart.

Optional Feature:
- Macro: MGMT_IRQ_COALESCE_STATS_EN.
- When defined, adds two ports:
  - irq_count (out, 16): increments on each entry to ASSERTED and wraps.
  - max_wait (out, TIMER_WIDTH): the largest ARMED timer value seen at ASSERTED entry, saturating.
  - Both are cleared by reset only.
- When not defined, these ports and their logic are absent. Core behaviour is identical either way.

Test Plan:
- Reset, then threshold=1, timeout=100, gap=0; commit pulse in cycle 5 → irq=1 from cycle 6, pending_count=1; irq_ack in cycle 10 → irq=0 in cycle 11, state ARMED, irq=1 again by the timeout 100 cycles later unless popped first.
- Threshold=4, timeout=1000; four commits spaced 10 cycles apart → irq stays 0 until the edge of the 4th commit, then irq=1 on the next cycle; four pops → pending_count=0, irq drops without an ack, state IDLE.
- Threshold=8, timeout=50; single commit → irq rises exactly 50 cycles after ARMED entry; max_wait=49 when MGMT_IRQ_COALESCE_STATS_EN is defined.
- Gap=20; ack with 2 frames still pending → irq low for exactly 20 cycles, then ARMED; commits inside the gap increase pending_count but irq stays 0.
- Commit and pop in the same cycle at count 3 → count stays 3; pop at count 0 → err_underflow=1 and stays set; 64 commits with COUNT_WIDTH=6 → count holds at 63 and err_overflow=1.
- Drop link_up while irq=1 and count=5 → next cycle irq=0, count=0, state IDLE; assert reset mid-GAP → all outputs return to reset values on the next edge.
